// File: rtl/bitutils_pkg.sv
// Shared bit-manipulation types and helper functions used by the execute stage.
// Holds the word and register types, the unit's opcodes and FSM states, and the permutation primitives.
package bitutils;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  gpr_addr_t;

    typedef enum logic [3:0] {
        ROLB   = 4'd0,
        BREV8  = 4'd1,
        ZIP    = 4'd2,
        UNZIP  = 4'd3,
        XPERM8 = 4'd4,
        XPERM4 = 4'd5,
        PACK   = 4'd6,
        PACKH  = 4'd7,
        CLMUL  = 4'd8,
        CLMULH = 4'd9,
        CLMULR = 4'd10
    } bmu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } bmu_state_t;

    function automatic word_t rol32_byte(word_t x, logic [1:0] n);
        word_t r;
        case (n)
            2'd1:    r = {x[23:0], x[31:24]};
            2'd2:    r = {x[15:0], x[31:16]};
            2'd3:    r = {x[7:0],  x[31:8]};
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] bit_reverse_in_byte(logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // Low half lands on even bits, high half on odd bits.
    function automatic word_t zip_word(word_t x);
        word_t r;
        for (int i = 0; i < 16; i++) begin
            r[2*i]   = x[i];
            r[2*i+1] = x[i+16];
        end
        return r;
    endfunction

    function automatic word_t unzip_word(word_t x);
        word_t r;
        for (int i = 0; i < 16; i++) begin
            r[i]    = x[2*i];
            r[i+16] = x[2*i+1];
        end
        return r;
    endfunction

    function automatic logic [7:0] xperm_byte(logic [7:0] idx, word_t lut);
        return (idx[7:2] != 6'd0) ? 8'h00 : lut[{idx[1:0], 3'b000} +: 8];
    endfunction

    function automatic logic [3:0] xperm_nibble(logic [3:0] idx, word_t lut);
        return idx[3] ? 4'h0 : lut[{idx[2:0], 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/clmul_iter_step.sv
// One carry-less multiply iteration: folds BPC multiplier bits starting at bit_off_i
// into the 64-bit accumulator.
module clmul_iter_step #(
    parameter int BPC = 4
) (
    input  logic [63:0]    acc_i,
    input  logic [31:0]    src1_i,
    input  logic [BPC-1:0] mbits_i,
    input  logic [5:0]     bit_off_i,
    output logic [63:0]    acc_o
);

    always_comb begin
        acc_o = acc_i;
        for (int j = 0; j < BPC; j++) begin
            if (mbits_i[j]) acc_o = acc_o ^ ({32'b0, src1_i} << (bit_off_i + 6'(j)));
        end
    end

endmodule

// File: rtl/bitmanip_exec_unit.sv
// Execute-stage unit for scalar bit-manipulation/crypto ops: one-cycle permutations,
// iterative carry-less multiply, registered result held until writeback takes it.
module bitmanip_exec_unit
    import bitutils::*;
#(
    parameter int CLMUL_BPC = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush_i,
    input  logic      in_valid_i,
    output logic      in_ready_o,
    input  bmu_op_t   op_i,
    input  word_t     src1_i,
    input  word_t     src2_i,
    input  gpr_addr_t rd_i,
    output logic      out_valid_o,
    input  logic      out_ready_i,
    output word_t     result_o,
    output gpr_addr_t rd_o,
    output logic      busy_o
);

    localparam int K_CLMUL = 32 / CLMUL_BPC;
    localparam int CNT_W   = (K_CLMUL > 1) ? $clog2(K_CLMUL) : 1;

    bmu_state_t           state;
    bmu_op_t              op_p1;
    word_t                src1_p1;
    word_t                src2_p1;
    gpr_addr_t            rd_p1;
    word_t                result_p1;
    logic [63:0]          acc_p1;
    logic [CNT_W-1:0]     cnt_p1;
    logic [63:0]          acc_next;
    logic [5:0]           bit_off;
    logic [CLMUL_BPC-1:0] mbits;
    logic                 accept;

    function automatic logic is_clmul(bmu_op_t op);
        return (op == CLMUL) || (op == CLMULH) || (op == CLMULR);
    endfunction

    function automatic word_t perm_result(bmu_op_t op, word_t a, word_t b);
        word_t r;
        r = '0;
        case (op)
            ROLB:   r = rol32_byte(a, b[1:0]);
            BREV8:  for (int i = 0; i < 4; i++) r[8*i +: 8] = bit_reverse_in_byte(a[8*i +: 8]);
            ZIP:    r = zip_word(a);
            UNZIP:  r = unzip_word(a);
            XPERM8: for (int i = 0; i < 4; i++) r[8*i +: 8] = xperm_byte(b[8*i +: 8], a);
            XPERM4: for (int i = 0; i < 8; i++) r[4*i +: 4] = xperm_nibble(b[4*i +: 4], a);
            PACK:   r = {b[15:0], a[15:0]};
            PACKH:  r = {16'h0, b[7:0], a[7:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic word_t clmul_select(bmu_op_t op, logic [63:0] acc);
        word_t r;
        case (op)
            CLMULH:  r = acc[63:32];
            CLMULR:  r = acc[62:31];
            default: r = acc[31:0];
        endcase
        return r;
    endfunction

    assign in_ready_o  = !flush_i && ((state == IDLE) || ((state == DONE) && out_ready_i));
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = (state == DONE);
    assign busy_o      = (state != IDLE);
    assign result_o    = result_p1;
    assign rd_o        = rd_p1;

    // CALC datapath: slice the latched multiplier for this iteration
    assign bit_off = 6'(32'(cnt_p1) * CLMUL_BPC);
    assign mbits   = CLMUL_BPC'(src2_p1 >> bit_off);

    clmul_iter_step #(
        .BPC(CLMUL_BPC)
    ) u_step (
        .acc_i    (acc_p1),
        .src1_i   (src1_p1),
        .mbits_i  (mbits),
        .bit_off_i(bit_off),
        .acc_o    (acc_next)
    );

    // Stage p1: FSM, operand latch and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_p1     <= ROLB;
            src1_p1   <= '0;
            src2_p1   <= '0;
            rd_p1     <= '0;
            result_p1 <= '0;
            acc_p1    <= '0;
            cnt_p1    <= '0;
        end else if (flush_i) begin
            state <= IDLE;
        end else if (accept) begin
            op_p1   <= op_i;
            src1_p1 <= src1_i;
            src2_p1 <= src2_i;
            rd_p1   <= rd_i;
            if (is_clmul(op_i)) begin
                state  <= CALC;
                acc_p1 <= '0;
                cnt_p1 <= '0;
            end else begin
                state     <= DONE;
                result_p1 <= perm_result(op_i, src1_i, src2_i);
            end
        end else begin
            case (state)
                CALC: begin
                    acc_p1 <= acc_next;
                    cnt_p1 <= cnt_p1 + 1'b1;
                    if (cnt_p1 == CNT_W'(K_CLMUL - 1)) begin
                        state     <= DONE;
                        result_p1 <= clmul_select(op_p1, acc_next);
                    end
                end
                DONE: begin
                    if (out_ready_i) state <= IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bitmanip_exec_unit.sv
// Scoreboard bench for bitmanip_exec_unit: expected results are queued at accept
// and compared whenever writeback takes a result.
module tb_bitmanip_exec_unit;
    import bitutils::*;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    logic      flush = 1'b0;
    logic      in_valid = 1'b0;
    logic      in_ready;
    bmu_op_t   op_in = ROLB;
    word_t     src1 = '0;
    word_t     src2 = '0;
    gpr_addr_t rd_in = '0;
    logic      out_valid;
    logic      out_ready = 1'b1;
    word_t     result;
    gpr_addr_t rd_out;
    logic      busy;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   last_wait;

    bitmanip_exec_unit #(.CLMUL_BPC(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .op_i       (op_in),
        .src1_i     (src1),
        .src2_i     (src2),
        .rd_i       (rd_in),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o   (result),
        .rd_o       (rd_out),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] clmul_model(word_t a, word_t b);
        logic [63:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) if (b[i]) acc = acc ^ ({32'b0, a} << i);
        return acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Call 1ns after a rising edge; returns 1ns after the accepting edge.
    task automatic send(bmu_op_t op, word_t a, word_t b, gpr_addr_t rd, word_t exp, bit expect_out);
        int n;
        n = 0;
        in_valid = 1'b1;
        op_in = op;
        src1 = a;
        src2 = b;
        rd_in = rd;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        if (!in_ready) chk("accept_timeout", 0, 1);
        else if (expect_out) sb.push_back('{exp, rd});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts rising edges after the accept edge until out_valid is seen (0 = next cycle).
    task automatic wait_valid(output int n);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            chk("valid_timeout", 0, 1);
            n = -1;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_result", result, e.res);
                chk("sb_rd", rd_out, e.rd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        word_t ra, rb, r0;
        gpr_addr_t d0;

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_rd", rd_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        send(BREV8, 32'h01020408, 32'h0, 5'd7, 32'h80402010, 1'b1);
        wait_valid(n);
        chk("brev8_lat", n, 0);
        tick();

        send(ZIP, 32'hFFFF0000, 32'h0, 5'd3, 32'hAAAAAAAA, 1'b1);
        send(UNZIP, 32'hAAAAAAAA, 32'h0, 5'd4, 32'hFFFF0000, 1'b1);
        chk("b2b_no_wait", last_wait, 0);
        @(negedge clk);
        chk("b2b_valid", out_valid, 1);
        tick();

        send(XPERM8, 32'h44332211, 32'h00010203, 5'd5, 32'h11223344, 1'b1);
        send(XPERM8, 32'h44332211, 32'h04010203, 5'd6, 32'h00223344, 1'b1);
        send(XPERM4, 32'hFEDCBA98, 32'h80000123, 5'd8, 32'h088889AB, 1'b1);
        send(ROLB, 32'h11223344, 32'h00000001, 5'd9, 32'h22334411, 1'b1);
        send(PACK, 32'hAAAA1234, 32'hBBBB5678, 5'd10, 32'h56781234, 1'b1);
        send(bmu_op_t'(4'd15), 32'hDEADBEEF, 32'hFFFFFFFF, 5'd11, 32'h0, 1'b1);
        tick();

        send(CLMUL, 32'h80000003, 32'h00000003, 5'd12, 32'h80000005, 1'b1);
        wait_valid(n);
        chk("clmul_lat", n, 8);
        tick();
        send(CLMULH, 32'h80000003, 32'h00000003, 5'd13, 32'h00000001, 1'b1);
        wait_valid(n);
        chk("clmulh_lat", n, 8);
        tick();
        for (int k = 0; k < 3; k++) begin
            ra = $urandom;
            rb = $urandom;
            send(CLMULR, ra, rb, 5'(14 + k), clmul_model(ra, rb) >> 31, 1'b1);
            wait_valid(n);
            tick();
        end

        // Backpressure: result held, then release and accept in the same cycle
        out_ready = 1'b0;
        send(BREV8, 32'h80C0E0F0, 32'h0, 5'd20, 32'h0103070F, 1'b1);
        wait_valid(n);
        r0 = result;
        d0 = rd_out;
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            chk("bp_result_stable", result, r0);
            chk("bp_rd_stable", rd_out, d0);
            chk("bp_in_ready", in_ready, 0);
        end
        tick();
        out_ready = 1'b1;
        send(PACK, 32'h0000BEEF, 32'h0000CAFE, 5'd21, 32'hCAFEBEEF, 1'b1);
        chk("bp_same_cycle_accept", last_wait, 0);
        @(negedge clk);
        chk("bp_no_bubble", out_valid, 1);
        tick();

        // Flush in the 3rd CALC cycle
        send(CLMUL, 32'h12345678, 32'h9ABCDEF0, 5'd22, 32'h0, 1'b0);
        tick();
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready_after", in_ready, 1);
        chk("flush_busy", busy, 0);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_valid", seen, 0);
        tick();
        send(PACKH, 32'h00000012, 32'h00000034, 5'd23, 32'h00003412, 1'b1);
        wait_valid(n);
        chk("packh_lat", n, 0);
        tick();

        // Reset pulse mid-CALC
        send(CLMUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd24, 32'h0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_result", result, 0);
        chk("rstmid_rd", rd_out, 0);
        chk("rstmid_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_in_ready", in_ready, 1);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("rstmid_no_valid", seen, 0);

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitmanip_exec_unit.md
Name: bitmanip_exec_unit

Overview:
- Execute-stage functional unit for the scalar bit-manipulation/crypto subset (Zbkb/Zbkx/Zbc-style ops).
- Takes decoded ops from issue with a valid/ready handshake and returns a registered result plus destination GPR index to writeback.
- Permutation ops complete in one cycle using the shared bitutils functions.
- Carry-less multiplies run on an iterative multi-cycle datapath.

Parameters:
- CLMUL_BPC, 4, multiplier bits consumed per CALC cycle; must divide 32 (1, 2, 4, 8, 16, 32).
- K_CLMUL, 32/CLMUL_BPC (derived localparam), number of CALC cycles.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; kills any in-flight op
- in_valid_i  in  1  op request valid
- in_ready_o  out  1  unit can accept an op this cycle
- op_i  in  4  bmu_op_t opcode
- src1_i  in  32  rs1 value / LUT / multiplicand
- src2_i  in  32  rs2 value / index / multiplier
- rd_i  in  5  destination gpr_addr_t
- out_valid_o  out  1  result valid
- out_ready_i  in  1  writeback accepts result
- result_o  out  32  result word
- rd_o  out  5  destination echoed
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid_o=0, result_o=0, rd_o=0, busy_o=0, accumulator and counter cleared.
- States:
  - IDLE: waiting for an op.
  - CALC: clmul iteration.
  - DONE: result held.
- in_ready_o = !flush_i && (state==IDLE || (state==DONE && out_ready_i)).
- Accept occurs when in_valid_i && in_ready_o. Operands, op and rd are latched on the accept edge.
- Single-cycle ops: go to DONE on the accept edge, so out_valid_o is high the next cycle (latency 1). Result is computed from the inputs and registered.
  - ROLB: rol32_byte(src1, src2[1:0]).
  - BREV8: bit_reverse_in_byte applied to each byte.
  - ZIP: zip_word(src1).
  - UNZIP: unzip_word(src1).
  - XPERM8: result byte i = xperm_byte(src2 byte i, src1); index >= 4 gives 0.
  - XPERM4: result nibble i = xperm_nibble(src2 nibble i, src1); index >= 8 gives 0.
  - PACK: {src2[15:0], src1[15:0]}.
  - PACKH: {16'h0, src2[7:0], src1[7:0]}.
  - Undefined opcode: result 0, latency 1, no error flag.
- CLMUL, CLMULH, CLMULR:
  - Accept edge enters CALC with a 64-bit acc=0 and a counter=0.
  - Each CALC cycle: for each of the CLMUL_BPC multiplier bits j at position p=cnt*BPC+j, if src2[p] then acc ^= src1 << p.
  - After K_CLMUL iterations, go to DONE; out_valid_o rises K_CLMUL cycles after the accept edge (8 with the default).
  - Result selection: CLMUL=acc[31:0], CLMULH=acc[63:32], CLMULR=acc[62:31].
- DONE: result_o and rd_o stay stable while out_valid_o && !out_ready_i.
  - out_ready_i=1 with no new accept: go to IDLE, out_valid_o drops next cycle.
  - out_ready_i=1 with a simultaneous accept: back-to-back, no bubble.
- out_valid_o is 0 in IDLE and CALC. result_o outside DONE holds its last value.
- flush_i (synchronous, dominates everything):
  - Next state is IDLE, out_valid_o=0 next cycle.
  - Any pending DONE result is dropped even if out_ready_i=1 that cycle.
  - in_valid_i is ignored that cycle.
- Reset mid-op: immediate abort to reset values; no output is produced afterward.

Decomposition:
- Add to package bitutils:
  - typedef enum logic[3:0] bmu_op_t with ROLB=0, BREV8=1, ZIP=2, UNZIP=3, XPERM8=4, XPERM4=5, PACK=6, PACKH=7, CLMUL=8, CLMULH=9, CLMULR=10.
  - typedef enum bmu_state_t with IDLE, CALC, DONE.
  - Existing word_t and gpr_addr_t are used for ports.
- One sub-module: clmul_iter_step. It is combinational: inputs acc, src1, BPC multiplier bits, bit offset; output next acc. It is instantiated once in the CALC path.

Test Plan:
- BREV8, src1=0x01020408: out_valid 1 cycle after accept, result 0x80402010, rd echoed.
- ZIP then UNZIP back-to-back with out_ready=1:
  - ZIP src1=0xFFFF0000 gives 0xAAAAAAAA.
  - UNZIP src1=0xAAAAAAAA gives 0xFFFF0000.
  - Results on consecutive cycles.
- XPERM8, src1=0x44332211, src2=0x00010203 gives 0x11223344. Repeat with src2=0x04010203 gives 0x00223344.
- CLMUL, src1=0x80000003, src2=0x00000003: out_valid exactly 8 cycles after accept, result 0x80000005. Same operands with CLMULH gives 0x00000001.
- Backpressure: hold out_ready=0 for 3 cycles in DONE. result_o/rd_o must stay stable and in_ready=0. Then out_ready=1 with in_valid=1 must accept the next op in the same cycle.
- Kill cases:
  - flush_i at the 3rd CALC cycle of CLMUL: out_valid never rises, in_ready=1 the following cycle, and a subsequent PACKH(0x12,0x34) gives 0x00003412.
  - rst_n pulse mid-CALC: all outputs 0 and in_ready=1 after release.
